// File: rtl/cost_rom_arbiter.sv
// Two-requester round-robin front end for a registered cost ROM: single or 8-beat row
// accesses, with each return tagged through the 2-cycle ROM latency back to its owner.
module cost_rom_arbiter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0,
    input  logic       burst0,
    input  logic [2:0] w0,
    input  logic [2:0] j0,
    input  logic       req1,
    input  logic       burst1,
    input  logic [2:0] w1,
    input  logic [2:0] j1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic [6:0] rdata0,
    output logic [2:0] rj0,
    output logic       rvalid1,
    output logic [6:0] rdata1,
    output logic [2:0] rj1,
    output logic [2:0] W,
    output logic [2:0] J,
    input  logic [6:0] Cost,
    output logic       busy
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_ptr;
    logic       r_bowner;
    logic [2:0] r_beat;

    logic       r_tag_v_p0;
    logic       r_tag_o_p0;
    logic [2:0] r_tag_j_p0;
    logic       r_tag_v_p1;
    logic       r_tag_o_p1;
    logic [2:0] r_tag_j_p1;

    logic       w_xfer;
    logic       w_sel;
    logic [2:0] w_sel_w;
    logic [2:0] w_sel_j;
    logic [2:0] w_j_next;

    // Arbitration: r_ptr names the preferred requester when both ask.
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        w_state_nxt = r_state;
        if (r_state == S_IDLE) begin
            if (req0 && (!req1 || !r_ptr)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
            if ((gnt0 && burst0) || (gnt1 && burst1)) begin
                w_state_nxt = S_BURST;
            end
        end else if (r_beat == 3'd7) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign w_xfer   = (req0 && gnt0) || (req1 && gnt1);
    assign w_sel    = gnt1;
    assign w_sel_w  = w_sel ? w1 : w0;
    assign w_sel_j  = w_sel ? j1 : j0;
    assign w_j_next = J + 3'd1;
    assign busy     = (r_state == S_BURST) || r_tag_v_p0 || r_tag_v_p1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_ptr      <= 1'b0;
            r_bowner   <= 1'b0;
            r_beat     <= 3'd0;
            W          <= 3'd0;
            J          <= 3'd0;
            r_tag_v_p0 <= 1'b0;
            r_tag_o_p0 <= 1'b0;
            r_tag_j_p0 <= 3'd0;
            r_tag_v_p1 <= 1'b0;
            r_tag_o_p1 <= 1'b0;
            r_tag_j_p1 <= 3'd0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= 7'd0;
            rdata1     <= 7'd0;
            rj0        <= 3'd0;
            rj1        <= 3'd0;
        end else begin
            r_state <= w_state_nxt;

            // Issue stage: address to the ROM plus the tag that will follow it (p0).
            if (w_xfer) begin
                r_ptr    <= ~w_sel;
                r_bowner <= w_sel;
                r_beat   <= 3'd1;
                W        <= w_sel_w;
                J        <= w_sel_j;
            end else if (r_state == S_BURST) begin
                r_beat <= r_beat + 3'd1;
                J      <= w_j_next;
            end
            r_tag_v_p0 <= w_xfer || (r_state == S_BURST);
            r_tag_o_p0 <= w_xfer ? w_sel : r_bowner;
            r_tag_j_p0 <= w_xfer ? w_sel_j : w_j_next;

            // ROM sampling stage: tag advances while the ROM registers W/J (p1).
            r_tag_v_p1 <= r_tag_v_p0;
            r_tag_o_p1 <= r_tag_o_p0;
            r_tag_j_p1 <= r_tag_j_p0;

            // Return stage: Cost is valid now and is steered to the tagged owner.
            rvalid0 <= r_tag_v_p1 && !r_tag_o_p1;
            rvalid1 <= r_tag_v_p1 && r_tag_o_p1;
            if (r_tag_v_p1 && !r_tag_o_p1) begin
                rdata0 <= Cost;
                rj0    <= r_tag_j_p1;
            end
            if (r_tag_v_p1 && r_tag_o_p1) begin
                rdata1 <= Cost;
                rj1    <= r_tag_j_p1;
            end
        end
    end

endmodule

// File: tb/tb_cost_rom_arbiter.sv
// Bench for cost_rom_arbiter: registered ROM model (Cost = 8*W_s + J_s), a return
// scoreboard filled at grant time, and one task per scenario.
module tb_cost_rom_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       req0, burst0, req1, burst1;
    logic [2:0] w0, j0, w1, j1;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [6:0] rdata0, rdata1, Cost;
    logic [2:0] rj0, rj1, W, J;
    logic [2:0] W_s = 3'd0;
    logic [2:0] J_s = 3'd0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        logic       own;
        logic [6:0] d;
        logic [2:0] j;
    } exp_t;
    exp_t q[$];

    cost_rom_arbiter dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .burst0(burst0), .w0(w0), .j0(j0),
        .req1(req1), .burst1(burst1), .w1(w1), .j1(j1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rdata0(rdata0), .rj0(rj0),
        .rvalid1(rvalid1), .rdata1(rdata1), .rj1(rj1),
        .W(W), .J(J), .Cost(Cost), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        W_s <= W;
        J_s <= J;
        cyc <= cyc + 1;
    end
    assign Cost = {1'b0, W_s, 3'b000} + {4'b0000, J_s};

    task automatic push_grant(input logic own, input logic bst, input logic [2:0] w, input logic [2:0] j);
        exp_t e;
        for (int k = 0; k < (bst ? 8 : 1); k++) begin
            e.due = cyc + 3 + k;
            e.own = own;
            e.j   = 3'((int'(j) + k) % 8);
            e.d   = 7'(8 * int'(w) + int'(e.j));
            q.push_back(e);
        end
    endtask

    // Scoreboard: compare returns against the queue, then record grants seen this cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            checks++;
            if (e.own == 1'b0 && (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== e.d || rj0 !== e.j)) begin
                failures++;
                $display("FAIL return0 cyc=%0d got v0=%b v1=%b d=%0d j=%0d want d=%0d j=%0d",
                         cyc, rvalid0, rvalid1, rdata0, rj0, e.d, e.j);
            end
            if (e.own == 1'b1 && (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== e.d || rj1 !== e.j)) begin
                failures++;
                $display("FAIL return1 cyc=%0d got v1=%b v0=%b d=%0d j=%0d want d=%0d j=%0d",
                         cyc, rvalid1, rvalid0, rdata1, rj1, e.d, e.j);
            end
        end else begin
            checks++;
            if ((rvalid0 | rvalid1) !== 1'b0) begin
                failures++;
                $display("FAIL spurious_rvalid cyc=%0d got v0=%b v1=%b want 0 0", cyc, rvalid0, rvalid1);
            end
        end
        if (RST) begin
            q.delete();
        end else begin
            if (req0 && gnt0) push_grant(1'b0, burst0, w0, j0);
            if (req1 && gnt1) push_grant(1'b1, burst1, w1, j1);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        {req0, burst0, req1, burst1} = 4'b0;
        {w0, j0, w1, j1} = 12'd0;
        tick();
        tick();
        @(negedge CLK);
        checks++;
        if (W !== 3'd0 || J !== 3'd0) begin
            failures++; $display("FAIL reset_addr got W=%0d J=%0d want 0 0", W, J);
        end
        checks++;
        if (busy !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            failures++; $display("FAIL reset_ctl got busy=%b v0=%b v1=%b want 0", busy, rvalid0, rvalid1);
        end
        checks++;
        if (rdata0 !== 7'd0 || rdata1 !== 7'd0 || rj0 !== 3'd0 || rj1 !== 3'd0) begin
            failures++; $display("FAIL reset_data got %0d %0d %0d %0d want 0", rdata0, rdata1, rj0, rj1);
        end
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req0 = 1'b1; burst0 = 1'b0; w0 = 3'd3; j0 = 3'd5;
        @(negedge CLK);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++; $display("FAIL single_gnt got %b%b want 10", gnt0, gnt1);
        end
        tick();
        req0 = 1'b0;
        @(negedge CLK);
        checks++;
        if (W !== 3'd3 || J !== 3'd5 || busy !== 1'b1) begin
            failures++; $display("FAIL single_addr got W=%0d J=%0d busy=%b want 3 5 1", W, J, busy);
        end
        tick();
        tick();
        @(negedge CLK);
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 7'd29 || rj0 !== 3'd5 || rvalid1 !== 1'b0) begin
            failures++; $display("FAIL single_ret got v0=%b d=%0d j=%0d v1=%b want 1 29 5 0", rvalid0, rdata0, rj0, rvalid1);
        end
        tick();
        tick();
        @(negedge CLK);
        checks++;
        if (W !== 3'd3 || J !== 3'd5 || busy !== 1'b0 || rvalid0 !== 1'b0) begin
            failures++; $display("FAIL single_hold got W=%0d J=%0d busy=%b v0=%b want 3 5 0 0", W, J, busy, rvalid0);
        end
        tick();
    endtask

    task automatic test_both();
        do_reset();
        req0 = 1'b1; burst0 = 1'b0; w0 = 3'd1; j0 = 3'd0;
        req1 = 1'b1; burst1 = 1'b0; w1 = 3'd4; j1 = 3'd2;
        @(negedge CLK);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++; $display("FAIL both_first got %b%b want 10", gnt0, gnt1);
        end
        tick();
        req0 = 1'b0;
        @(negedge CLK);
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
            failures++; $display("FAIL both_second got %b%b want 01", gnt0, gnt1);
        end
        tick();
        req1 = 1'b0;
        tick();
        @(negedge CLK);
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 7'd8) begin
            failures++; $display("FAIL both_ret0 got v=%b d=%0d want 1 8", rvalid0, rdata0);
        end
        tick();
        @(negedge CLK);
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 7'd34 || rj1 !== 3'd2) begin
            failures++; $display("FAIL both_ret1 got v=%b d=%0d j=%0d want 1 34 2", rvalid1, rdata1, rj1);
        end
        tick();
        tick();
    endtask

    task automatic test_burst();
        req1 = 1'b1; burst1 = 1'b1; w1 = 3'd2; j1 = 3'd6;
        @(negedge CLK);
        checks++;
        if (gnt1 !== 1'b1) begin
            failures++; $display("FAIL burst_gnt got %b want 1", gnt1);
        end
        tick();
        req1 = 1'b0; burst1 = 1'b0;
        req0 = 1'b1; burst0 = 1'b0; w0 = 3'd7; j0 = 3'd7;
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            checks++;
            if (gnt0 !== 1'b0 || busy !== 1'b1 || W !== 3'd2 || J !== 3'((6 + k) % 8)) begin
                failures++;
                $display("FAIL burst_beat%0d got gnt0=%b busy=%b W=%0d J=%0d want 0 1 2 %0d",
                         k, gnt0, busy, W, J, (6 + k) % 8);
            end
            tick();
        end
        @(negedge CLK);
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++; $display("FAIL burst_after_gnt0 got %b want 1", gnt0);
        end
        tick();
        req0 = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset_burst();
        req0 = 1'b1; burst0 = 1'b1; w0 = 3'd5; j0 = 3'd1;
        @(negedge CLK);
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++; $display("FAIL rburst_gnt got %b want 1", gnt0);
        end
        tick();
        req0 = 1'b0; burst0 = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        req0 = 1'b1; w0 = 3'd0; j0 = 3'd3;
        req1 = 1'b1; burst1 = 1'b0; w1 = 3'd6; j1 = 3'd4;
        @(negedge CLK);
        checks++;
        if (rvalid0 !== 1'b0 || W !== 3'd0 || J !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL rburst_state got v0=%b W=%0d J=%0d busy=%b want 0 0 0 0", rvalid0, W, J, busy);
        end
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++; $display("FAIL rburst_first got %b%b want 10", gnt0, gnt1);
        end
        tick();
        req0 = 1'b0;
        tick();
        req1 = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_back_to_back();
        int exp_own;
        do_reset();
        req0 = 1'b1; burst0 = 1'b0; w0 = 3'd1; j0 = 3'd1;
        req1 = 1'b1; burst1 = 1'b0; w1 = 3'd6; j1 = 3'd3;
        for (int k = 0; k < 6; k++) begin
            exp_own = k % 2;
            @(negedge CLK);
            checks++;
            if (gnt0 !== (exp_own == 0) || gnt1 !== (exp_own == 1)) begin
                failures++; $display("FAIL b2b_gnt%0d got %b%b want owner %0d", k, gnt0, gnt1, exp_own);
            end
            tick();
            if (exp_own == 0) begin
                w0 = w0 + 3'd1; j0 = j0 + 3'd3;
            end else begin
                w1 = w1 + 3'd1; j1 = j1 + 3'd3;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) tick();
        @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            failures++; $display("FAIL b2b_drain got %0d pending want 0", q.size());
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_both();
        test_burst();
        test_reset_burst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
